// File: rtl/sm4_pkg.sv
// Shared constants and types for the SM4 key schedule.
package sm4_pkg;

   localparam logic [31:0] FK0 = 32'ha3b1bac6;
   localparam logic [31:0] FK1 = 32'h56aa3350;
   localparam logic [31:0] FK2 = 32'h677d9197;
   localparam logic [31:0] FK3 = 32'hb27022dc;

   localparam int ROUNDS = 32;
   localparam int LROT_A = 13;
   localparam int LROT_B = 23;

   typedef enum logic {
      IDLE   = 1'b0,
      EXPAND = 1'b1
   } state_t;

   function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

endpackage

// File: rtl/sm4_ck.sv
// SM4 CK constant generator: byte j of CK[i] is (4*i + j) * 7 mod 256.
module sm4_ck (
   input  logic [4:0]  round,
   output logic [31:0] ck
);

   for (genvar j = 0; j < 4; j++) begin : g_byte
      logic [7:0] n;
      assign n = {1'b0, round, 2'(j)};
      assign ck[31 - 8*j -: 8] = n * 8'd7;
   end

endmodule

// File: rtl/sm4_key_t.sv
// Key-schedule T' transform: byte-wise S-box (tau) followed by L'(x) = x ^ (x<<<13) ^ (x<<<23).
module sm4_key_t
   import sm4_pkg::*;
(
   input  logic [31:0] din,
   output logic [31:0] dout
);

   logic [31:0] sub;

   for (genvar i = 0; i < 4; i++) begin : g_sb
      sm4_sbox u_sbox (
         .din  (din[8*i +: 8]),
         .dout (sub[8*i +: 8])
      );
   end

   assign dout = sub ^ rotl(sub, LROT_A) ^ rotl(sub, LROT_B);

endmodule

// File: rtl/sm4_sbox.sv
// SM4 8-bit S-box, pure lookup.
module sm4_sbox (
   input  logic [7:0] din,
   output logic [7:0] dout
);

   localparam logic [7:0] SBOX [256] = '{
      8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
      8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
      8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
      8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
      8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
      8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
      8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
      8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
      8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
      8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
      8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
      8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
      8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
      8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
      8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
      8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
   };

   assign dout = SBOX[din];

endmodule

// File: rtl/sm4_key_expand.sv
// SM4 key schedule: expands a 128-bit master key into 32 round keys, one per clock,
// streaming them out and optionally keeping them in a key file for reverse-order reads.
//
//   state  | meaning
//   IDLE   | key_ready high, waiting for a master key; rk_valid low
//   EXPAND | producing rk[round] each cycle; leaves after round 31
module sm4_key_expand
   import sm4_pkg::*;
#(
   parameter bit STORE_KEYS = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [127:0] key_in,
   input  logic         key_valid,
   output logic         key_ready,
   output logic         rk_valid,
   output logic [31:0]  rk_out,
   output logic [4:0]   rk_idx,
   output logic         key_ok,
   input  logic [4:0]   rk_raddr,
   output logic [31:0]  rk_rdata
);

   state_t      state;
   logic [4:0]  round;
   logic [31:0] k0, k1, k2, k3;
   logic [31:0] ck, t_in, t_out, rk;

   sm4_ck u_ck (
      .round (round),
      .ck    (ck)
   );

   assign t_in = k1 ^ k2 ^ k3 ^ ck;

   sm4_key_t u_key_t (
      .din  (t_in),
      .dout (t_out)
   );

   assign rk = k0 ^ t_out;

   // FSM, round counter, key shift register and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         key_ready <= 1'b1;
         rk_valid  <= 1'b0;
         rk_out    <= '0;
         rk_idx    <= '0;
         key_ok    <= 1'b0;
         round     <= '0;
         k0        <= '0;
         k1        <= '0;
         k2        <= '0;
         k3        <= '0;
      end else begin
         case (state)
            IDLE: begin
               rk_valid <= 1'b0;
               if (key_valid && key_ready) begin
                  k0        <= key_in[127:96] ^ FK0;
                  k1        <= key_in[95:64]  ^ FK1;
                  k2        <= key_in[63:32]  ^ FK2;
                  k3        <= key_in[31:0]   ^ FK3;
                  round     <= '0;
                  key_ok    <= 1'b0;
                  key_ready <= 1'b0;
                  state     <= EXPAND;
               end
            end
            EXPAND: begin
               k0       <= k1;
               k1       <= k2;
               k2       <= k3;
               k3       <= rk;
               rk_out   <= rk;
               rk_idx   <= round;
               rk_valid <= 1'b1;
               // 31 -> 0 wrap coincides with the exit to IDLE
               round    <= round + 5'd1;
               if (round == 5'(ROUNDS - 1)) begin
                  state     <= IDLE;
                  key_ready <= 1'b1;
                  key_ok    <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   if (STORE_KEYS) begin : g_keyfile
      logic [31:0] kf [ROUNDS];

      // key file write; the async read below sees the pre-write contents in the write cycle
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < ROUNDS; i++) kf[i] <= '0;
         end else if (state == EXPAND) begin
            kf[round] <= rk;
         end
      end

      assign rk_rdata = kf[rk_raddr];
   end else begin : g_no_keyfile
      logic unused_raddr;
      assign unused_raddr = ^rk_raddr;
      assign rk_rdata     = '0;
   end

endmodule
